// File: rtl/sd_cmd_tx_ctrl.sv
// rtl/sd_cmd_tx_ctrl.sv - SD CMD-line frame transmitter with serial CRC7 and idle gap
module sd_cmd_tx_ctrl #(
  parameter int NumGapBits = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sd_tick_i,
  input  logic        abort_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        cmd_o,
  output logic        cmd_oe_o
);

  localparam int GapW = (NumGapBits > 1) ? $clog2(NumGapBits) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, GAP} state_t;

  state_t            state;
  logic [39:0]       sreg;
  logic [6:0]        crc;
  logic [5:0]        bit_cnt;
  logic [GapW-1:0]   gap_cnt;

  logic              fb;
  logic [6:0]        crc_nxt;
  logic [5:0]        nxt_idx;
  logic [2:0]        crc_sel;
  logic              nxt_bit;
  logic              xfer;

  assign xfer = cmd_valid_i && cmd_ready_o && !abort_i;

  // bit_cnt is the frame index currently on the line; nxt_bit is what follows it
  always_comb begin
    fb      = sreg[39] ^ crc[6];
    crc_nxt = crc;
    if (bit_cnt >= 6'd8) begin
      crc_nxt = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    nxt_idx = bit_cnt - 6'd1;
    crc_sel = 3'(nxt_idx - 6'd1);
    if (nxt_idx >= 6'd8) begin
      nxt_bit = sreg[38];
    end else if (nxt_idx != 6'd0) begin
      nxt_bit = crc_nxt[crc_sel];
    end else begin
      nxt_bit = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      sreg        <= '0;
      crc         <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cmd_o       <= 1'b1;
      cmd_oe_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state       <= IDLE;
        cmd_ready_o <= 1'b1;
        busy_o      <= 1'b0;
        cmd_o       <= 1'b1;
        cmd_oe_o    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (xfer) begin
              sreg        <= {1'b0, 1'b1, cmd_index_i, cmd_arg_i};
              crc         <= '0;
              state       <= WAIT;
              cmd_ready_o <= 1'b0;
              busy_o      <= 1'b1;
            end
          end
          WAIT: begin
            if (sd_tick_i) begin
              cmd_oe_o <= 1'b1;
              cmd_o    <= sreg[39];
              bit_cnt  <= 6'd47;
              state    <= SHIFT;
            end
          end
          SHIFT: begin
            if (sd_tick_i) begin
              if (bit_cnt != 6'd0) begin
                crc     <= crc_nxt;
                sreg    <= {sreg[38:0], 1'b0};
                bit_cnt <= nxt_idx;
                cmd_o   <= nxt_bit;
              end else begin
                cmd_oe_o <= 1'b0;
                cmd_o    <= 1'b1;
                done_o   <= 1'b1;
                gap_cnt  <= GapW'(NumGapBits - 1);
                state    <= GAP;
              end
            end
          end
          GAP: begin
            if (sd_tick_i) begin
              if (gap_cnt == '0) begin
                state       <= IDLE;
                cmd_ready_o <= 1'b1;
                busy_o      <= 1'b0;
              end else begin
                gap_cnt <= gap_cnt - GapW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_tx_ctrl.sv
// tb/tb_sd_cmd_tx_ctrl.sv - scoreboard bench for sd_cmd_tx_ctrl
module tb_sd_cmd_tx_ctrl;

  localparam int NGAP = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sd_tick;
  logic        abort;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        busy;
  logic        done;
  logic        cmd_line;
  logic        cmd_oe;

  sd_cmd_tx_ctrl #(.NumGapBits(NGAP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sd_tick_i   (sd_tick),
    .abort_i     (abort),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_index_i (cmd_index),
    .cmd_arg_i   (cmd_arg),
    .busy_o      (busy),
    .done_o      (done),
    .cmd_o       (cmd_line),
    .cmd_oe_o    (cmd_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int exp_frames = 0;
  int frames_done = 0;
  int done_seen = 0;
  logic [47:0] sb_q[$];

  int  tick_div = 4;
  bit  tick_en = 1'b1;
  bit  force_tick = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  // Reference frame: CRC7 as polynomial remainder of header * x^7 mod x^7+x^3+1
  function automatic logic [47:0] sd_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] hdr;
    logic [46:0] v;
    hdr = {2'b01, idx, arg};
    v = {hdr, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (v[i]) v = v ^ (47'h89 << (i - 7));
    end
    return {hdr, v[6:0], 1'b1};
  endfunction

  initial begin
    int div;
    div = 0;
    sd_tick = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (force_tick) begin
        sd_tick = 1'b1;
        force_tick = 1'b0;
        div = 0;
      end else if (tick_en) begin
        div++;
        if (div >= tick_div) begin
          sd_tick = 1'b1;
          div = 0;
        end else begin
          sd_tick = 1'b0;
        end
      end else begin
        sd_tick = 1'b0;
      end
    end
  end

  // Monitor: reassembles serial frames and checks them against the scoreboard
  logic        tick_q = 1'b0, xfer_q = 1'b0, abort_q = 1'b0;
  bit          waiting = 0, collecting = 0, gap_active = 0;
  int          nbits = 0, gap_n = 0;
  logic [47:0] frame = '0;
  logic        last_bit = 1'b1;

  always @(posedge clk) begin
    tick_q  <= sd_tick;
    xfer_q  <= cmd_valid && cmd_ready && !abort && rst_n;
    abort_q <= abort && rst_n;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      waiting = 0; collecting = 0; gap_active = 0;
      sb_q.delete();
    end else if (abort_q) begin
      check("abort_oe", cmd_oe, 1'b0);
      check("abort_cmd", cmd_line, 1'b1);
      check("abort_ready", cmd_ready, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      waiting = 0; collecting = 0; gap_active = 0;
      sb_q.delete();
    end else begin
      if (done) done_seen++;
      if (gap_active && tick_q) gap_n++;
      if (gap_active && cmd_ready) begin
        check("gap_strobes", gap_n, NGAP);
        gap_active = 0;
      end
      if (xfer_q) begin
        check("xfer_oe_low", cmd_oe, 1'b0);
        waiting = 1; collecting = 0; nbits = 0;
      end else if (tick_q && waiting) begin
        check("first_bit_oe", cmd_oe, 1'b1);
        waiting = 0; collecting = 1; nbits = 1;
        frame = {47'b0, cmd_line};
        last_bit = cmd_line;
      end else if (tick_q && collecting) begin
        if (cmd_oe) begin
          frame = {frame[46:0], cmd_line};
          nbits++;
          last_bit = cmd_line;
        end else begin
          collecting = 0;
          check("done_pulse", done, 1'b1);
          check("bit_count", nbits, 48);
          check("line_release", cmd_line, 1'b1);
          if (sb_q.size() == 0) begin
            check("sb_empty", frame, 48'h0);
          end else begin
            check("frame", frame, sb_q.pop_front());
          end
          frames_done++;
          gap_active = 1; gap_n = 0;
        end
      end else if (collecting) begin
        check("hold_oe", cmd_oe, 1'b1);
        check("hold_cmd", cmd_line, last_bit);
        check("hold_busy", busy, 1'b1);
      end
    end
  end

  task automatic send(input logic [5:0] idx, input logic [31:0] arg, input logic [47:0] exp,
                      input bit force_t);
    int n;
    n = 0;
    @(negedge clk);
    cmd_index = idx;
    cmd_arg = arg;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", cmd_ready, 1'b1);
    if (cmd_ready) begin
      sb_q.push_back(exp);
      exp_frames++;
      if (force_t) force_tick = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_index = 6'($urandom);
      cmd_arg = $urandom;
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic send_rand(input bit force_t);
    logic [5:0]  idx;
    logic [31:0] arg;
    idx = 6'($urandom);
    arg = $urandom;
    send(idx, arg, sd_frame(idx, arg), force_t);
  endtask

  task automatic wait_bits(input int k);
    int n;
    n = 0;
    while (!(collecting && nbits >= k) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("bit_wait", collecting && nbits >= k, 1'b1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!(cmd_ready && !collecting && !waiting && !gap_active) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", cmd_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    cmd_valid = 1'b0;
    cmd_index = '0;
    cmd_arg = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cmd", cmd_line, 1'b1);
    check("rst_oe", cmd_oe, 1'b0);
    rst_n = 1'b1;

    tick_div = 4;
    send(6'd0, 32'h0, 48'h40_00000000_95, 0);
    wait_ready();

    tick_div = 3;
    send(6'd8, 32'h000001AA, 48'h48_000001AA_87, 0);
    send(6'd17, 32'h0, 48'h51_00000000_55, 0);
    wait_ready();

    tick_div = 5;
    send_rand(1);
    wait_ready();

    tick_div = 2;
    send_rand(0);
    wait_bits(30);
    tick_en = 1'b0;
    repeat (50) @(negedge clk);
    tick_en = 1'b1;
    wait_ready();

    tick_div = 3;
    send_rand(0);
    wait_bits(20);
    abort = 1'b1;
    exp_frames--;
    @(negedge clk);
    abort = 1'b0;
    send_rand(0);
    wait_ready();

    @(negedge clk);
    cmd_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    abort = 1'b0;
    check("idle_abort_ready", cmd_ready, 1'b1);
    check("idle_abort_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    check("idle_abort_no_xfer", busy, 1'b0);

    send_rand(0);
    wait_bits(44);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_frames--;
    #1;
    check("arst_oe", cmd_oe, 1'b0);
    check("arst_cmd", cmd_line, 1'b1);
    check("arst_ready", cmd_ready, 1'b1);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(6'd0, 32'h0, 48'h40_00000000_95, 0);
    wait_ready();

    for (int i = 0; i < 8; i++) begin
      tick_div = $urandom_range(1, 4);
      send_rand(bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) wait_ready();
    end
    wait_ready();
    repeat (20) @(negedge clk);

    check("frames_done", frames_done, exp_frames);
    check("done_pulses", done_seen, exp_frames);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
